// File: rtl/down_counter_seq_if.sv
// Handshake bundle for down_counter_seq: the requester drives start/load_val/en/abort,
// the counter returns its remaining count and one-hot ready/busy/done status.
interface down_counter_seq_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             abort;
    logic [WIDTH-1:0] q;
    logic             ready;
    logic             busy;
    logic             done;

    modport master (
        output start, load_val, en, abort,
        input  q, ready, busy, done
    );

    modport slave (
        input  start, load_val, en, abort,
        output q, ready, busy, done
    );
endinterface

// File: rtl/down_counter_seq.sv
// Loadable down-counter that runs N enabled steps and then pulses done for one cycle;
// status outputs are decoded purely from the state register.
module down_counter_seq #(
    parameter int WIDTH = 5
) (
    input logic            clk,
    input logic            clr,
    down_counter_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            count <= ZERO;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // RUN never holds a zero count: reaching one with en high finishes straight into DONE.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    count_next = bus.load_val;
                    state_next = (bus.load_val == ZERO) ? DONE : RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    count_next = ZERO;
                    state_next = IDLE;
                end else if (bus.en) begin
                    count_next = count - ONE;
                    if (count == ONE) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                count_next = ZERO;
                state_next = IDLE;
            end
            default: begin
                count_next = ZERO;
                state_next = IDLE;
            end
        endcase
    end

    assign bus.q     = count;
    assign bus.ready = (state == IDLE);
    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);

endmodule

// File: tb/tb_down_counter_seq.sv
// Self-checking bench for down_counter_seq: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_down_counter_seq;

    localparam int WIDTH = 5;

    logic clk;
    logic clr;
    int   n_checks;
    int   n_pass;

    // Behavioural model: remaining steps plus "working"/"finishing" flags.
    int   m_rem;
    bit   m_working;
    bit   m_finishing;
    bit   m_valid;
    bit   prev_done;

    down_counter_seq_if #(.WIDTH(WIDTH)) ifc ();

    down_counter_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input bit s, input int lv, input bit e, input bit a, input bit c);
        ifc.start    = s;
        ifc.load_val = WIDTH'(lv);
        ifc.en       = e;
        ifc.abort    = a;
        clr          = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int bound, output int cycles);
        cycles = 0;
        while (ifc.done !== 1'b1 && cycles < bound) begin
            tick();
            cycles++;
        end
    endtask

    // The model follows the rules in plain arithmetic, evaluated on the same edges the DUT sees.
    always @(posedge clk) begin
        if (clr) begin
            m_rem       = 0;
            m_working   = 0;
            m_finishing = 0;
            m_valid     = 1;
        end else if (m_finishing) begin
            m_finishing = 0;
            m_rem       = 0;
        end else if (m_working) begin
            if (ifc.abort) begin
                m_working = 0;
                m_rem     = 0;
            end else if (ifc.en) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_working   = 0;
                    m_finishing = 1;
                end
            end
        end else if (ifc.start) begin
            m_rem = int'(ifc.load_val);
            if (m_rem == 0) m_finishing = 1;
            else            m_working   = 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check_output("model_q", int'(ifc.q), m_rem);
            check_output("model_ready", int'(ifc.ready), int'(!m_working && !m_finishing));
            check_output("model_busy", int'(ifc.busy), int'(m_working));
            check_output("model_done", int'(ifc.done), int'(m_finishing));
            check_output("onehot_status", int'(ifc.ready) + int'(ifc.busy) + int'(ifc.done), 1);
            if (prev_done) check_output("done_not_twice", int'(ifc.done), 0);
            prev_done = ifc.done;
        end
    end

    initial begin
        int cycles;
        int lv;
        n_checks    = 0;
        n_pass      = 0;
        m_valid     = 0;
        m_rem       = 0;
        m_working   = 0;
        m_finishing = 0;
        prev_done   = 0;
        apply_stimulus(0, 0, 0, 0, 1);
        tick();
        tick();
        check_output("reset_q", int'(ifc.q), 0);
        check_output("reset_ready", int'(ifc.ready), 1);
        check_output("reset_done", int'(ifc.done), 0);
        apply_stimulus(0, 0, 0, 0, 0);
        tick();

        // N=5 with en held: q 5,4,3,2,1,0 and done on the fifth edge after start.
        apply_stimulus(1, 5, 1, 0, 0);
        tick();
        check_output("n5_loaded_q", int'(ifc.q), 5);
        apply_stimulus(0, 0, 1, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_output("n5_q", int'(ifc.q), 5 - k);
            check_output("n5_done", int'(ifc.done), (k == 5) ? 1 : 0);
        end
        tick();
        check_output("n5_ready_after", int'(ifc.ready), 1);

        // N=0 goes straight to done without ever being busy.
        apply_stimulus(1, 0, 1, 0, 0);
        tick();
        check_output("n0_done", int'(ifc.done), 1);
        check_output("n0_busy", int'(ifc.busy), 0);
        apply_stimulus(0, 0, 0, 0, 0);
        tick();
        check_output("n0_ready_after", int'(ifc.ready), 1);

        // N=4 with three stalled cycles finishes seven edges after start.
        apply_stimulus(1, 4, 1, 0, 0);
        tick();
        apply_stimulus(0, 0, 1, 0, 0);
        tick();
        tick();
        apply_stimulus(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output("stall_hold_q", int'(ifc.q), 2);
        end
        apply_stimulus(0, 0, 1, 0, 0);
        wait_done(20, cycles);
        check_output("stall_done_cycle", cycles + 5, 7);
        tick();

        // Restart attempt mid-run is ignored; abort at q=2 returns to idle without done.
        apply_stimulus(1, 6, 1, 0, 0);
        tick();
        apply_stimulus(1, 9, 1, 0, 0);
        tick();
        check_output("restart_ignored_q", int'(ifc.q), 5);
        apply_stimulus(0, 0, 1, 0, 0);
        tick();
        tick();
        tick();
        check_output("pre_abort_q", int'(ifc.q), 2);
        apply_stimulus(0, 0, 1, 1, 0);
        tick();
        check_output("abort_q", int'(ifc.q), 0);
        check_output("abort_ready", int'(ifc.ready), 1);
        check_output("abort_done", int'(ifc.done), 0);
        apply_stimulus(0, 0, 0, 0, 0);
        tick();
        check_output("abort_no_done_later", int'(ifc.done), 0);

        // Clear mid-run with q=7 wins over everything.
        apply_stimulus(1, 10, 1, 0, 0);
        tick();
        apply_stimulus(0, 0, 1, 0, 0);
        tick();
        tick();
        tick();
        check_output("pre_clr_q", int'(ifc.q), 7);
        apply_stimulus(0, 0, 1, 0, 1);
        tick();
        check_output("clr_q", int'(ifc.q), 0);
        check_output("clr_ready", int'(ifc.ready), 1);
        check_output("clr_busy", int'(ifc.busy), 0);
        check_output("clr_done", int'(ifc.done), 0);
        apply_stimulus(0, 0, 0, 0, 0);
        tick();

        // Full-scale count, then a back-to-back restart in the idle cycle after done.
        apply_stimulus(1, 31, 1, 0, 0);
        tick();
        apply_stimulus(0, 0, 1, 0, 0);
        wait_done(40, cycles);
        check_output("n31_done_cycle", cycles, 31);
        apply_stimulus(1, 31, 1, 0, 0);
        tick();
        check_output("b2b_idle_ready", int'(ifc.ready), 1);
        tick();
        check_output("b2b_accept_q", int'(ifc.q), 31);
        apply_stimulus(0, 0, 1, 0, 0);
        wait_done(40, cycles);
        check_output("b2b_done_cycle", cycles, 31);
        apply_stimulus(0, 0, 0, 0, 0);
        tick();

        // Random traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
            apply_stimulus($urandom_range(0, 9) < 3, lv, $urandom_range(0, 9) < 7,
                           $urandom_range(0, 39) == 0, $urandom_range(0, 99) < 2);
            tick();
        end
        apply_stimulus(0, 0, 0, 0, 0);
        tick();
        tick();

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
